// File: rtl/ser_pkg.sv
// Shared constants and types for the 288:72 serializer slice.
package ser_pkg;
   localparam int unsigned WIDTH  = 9;
   localparam int unsigned LANES  = 8;
   localparam int unsigned WORDS  = 32;
   localparam int unsigned PHASES = 4;

   typedef logic [WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_t;
endpackage

// File: rtl/ser36to9.sv
// One output lane: holds the four frame words for this lane and
// registers the word selected by the current phase.
module ser36to9
   import ser_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                phi_i,
   input  logic                      cap_i,
   input  logic [PHASES*WIDTH-1:0]   din_i,
   output logic [WIDTH-1:0]          out_o
);

   word_t w_q [PHASES];
   word_t w_d [PHASES];
   word_t out_q, out_d;

   // Output reads the old words, so at the capture edge words 24-31 of the
   // previous frame still leave while the new frame is loaded.
   always_comb begin
      w_d   = w_q;
      out_d = w_q[phi_i];
      if (cap_i) begin
         for (int unsigned p = 0; p < PHASES; p++) begin
            w_d[p] = din_i[p*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned p = 0; p < PHASES; p++) begin
            w_q[p] <= '0;
         end
         out_q <= '0;
      end else begin
         w_q   <= w_d;
         out_q <= out_d;
      end
   end

   assign out_o = out_q;

endmodule

// File: rtl/ser288to72.sv
// 288:72 serializer: one 32-word frame per 4 fast cycles, eight lanes out.
// Optional test-pattern source enabled by SER288TO72_PATTERN_EN.
module ser288to72
   import ser_pkg::*;
(
`ifdef SER288TO72_PATTERN_EN
   input  logic             pattern_en,
`endif
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       phi_init,
   input  logic [WIDTH-1:0] in_0,  input logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,  input logic [WIDTH-1:0] in_3,
   input  logic [WIDTH-1:0] in_4,  input logic [WIDTH-1:0] in_5,
   input  logic [WIDTH-1:0] in_6,  input logic [WIDTH-1:0] in_7,
   input  logic [WIDTH-1:0] in_8,  input logic [WIDTH-1:0] in_9,
   input  logic [WIDTH-1:0] in_10, input logic [WIDTH-1:0] in_11,
   input  logic [WIDTH-1:0] in_12, input logic [WIDTH-1:0] in_13,
   input  logic [WIDTH-1:0] in_14, input logic [WIDTH-1:0] in_15,
   input  logic [WIDTH-1:0] in_16, input logic [WIDTH-1:0] in_17,
   input  logic [WIDTH-1:0] in_18, input logic [WIDTH-1:0] in_19,
   input  logic [WIDTH-1:0] in_20, input logic [WIDTH-1:0] in_21,
   input  logic [WIDTH-1:0] in_22, input logic [WIDTH-1:0] in_23,
   input  logic [WIDTH-1:0] in_24, input logic [WIDTH-1:0] in_25,
   input  logic [WIDTH-1:0] in_26, input logic [WIDTH-1:0] in_27,
   input  logic [WIDTH-1:0] in_28, input logic [WIDTH-1:0] in_29,
   input  logic [WIDTH-1:0] in_30, input logic [WIDTH-1:0] in_31,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_0, output logic [WIDTH-1:0] out_1,
   output logic [WIDTH-1:0] out_2, output logic [WIDTH-1:0] out_3,
   output logic [WIDTH-1:0] out_4, output logic [WIDTH-1:0] out_5,
   output logic [WIDTH-1:0] out_6, output logic [WIDTH-1:0] out_7,
   output logic             out_valid,
   output logic             clkout_dsp,
   output logic             underflow
);

   word_t                    in_w     [WORDS];
   word_t                    lane_out [LANES];
   logic [PHASES*WIDTH-1:0]  lane_din [LANES];

   phase_t phi_q, phi_d;
   logic   fvalid_q, fvalid_d;
   logic   outv_q, outv_d;
   logic   clkout_q, clkout_d;
   logic   under_q, under_d;
   logic   capture, take;
`ifdef SER288TO72_PATTERN_EN
   word_t  pcnt_q, pcnt_d;
`endif

   assign in_w = '{in_0,  in_1,  in_2,  in_3,  in_4,  in_5,  in_6,  in_7,
                   in_8,  in_9,  in_10, in_11, in_12, in_13, in_14, in_15,
                   in_16, in_17, in_18, in_19, in_20, in_21, in_22, in_23,
                   in_24, in_25, in_26, in_27, in_28, in_29, in_30, in_31};

   assign capture = (phi_q == PH3);

`ifdef SER288TO72_PATTERN_EN
   assign take     = pattern_en | in_valid;
   assign in_ready = capture & ~pattern_en;
`else
   assign take     = in_valid;
   assign in_ready = capture;
`endif

   always_comb begin
      phi_d    = phase_t'(phi_q + 2'd1);
      clkout_d = (phi_q == PH3) || (phi_q == PH0);
      outv_d   = fvalid_q;
      fvalid_d = fvalid_q;
      under_d  = under_q;
      if (capture) begin
         fvalid_d = take;
         if (!take) under_d = 1'b1;
      end
`ifdef SER288TO72_PATTERN_EN
      pcnt_d = (capture && pattern_en) ? pcnt_q + 9'd32 : pcnt_q;
`endif
      // Word 8*p+k goes to lane k, phase slot p; an empty slot loads zeros.
      for (int unsigned k = 0; k < LANES; k++) begin
         lane_din[k] = '0;
         for (int unsigned p = 0; p < PHASES; p++) begin
`ifdef SER288TO72_PATTERN_EN
            if (pattern_en)
               lane_din[k][p*WIDTH +: WIDTH] = pcnt_q + word_t'(p*LANES + k);
            else
`endif
            if (in_valid)
               lane_din[k][p*WIDTH +: WIDTH] = in_w[p*LANES + k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phi_q    <= phase_t'(phi_init);
         fvalid_q <= 1'b0;
         outv_q   <= 1'b0;
         clkout_q <= (phi_init == 2'd3) || (phi_init == 2'd0);
         under_q  <= 1'b0;
`ifdef SER288TO72_PATTERN_EN
         pcnt_q   <= '0;
`endif
      end else begin
         phi_q    <= phi_d;
         fvalid_q <= fvalid_d;
         outv_q   <= outv_d;
         clkout_q <= clkout_d;
         under_q  <= under_d;
`ifdef SER288TO72_PATTERN_EN
         pcnt_q   <= pcnt_d;
`endif
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      ser36to9 u_lane (
         .clk   (clk),
         .rst   (rst),
         .phi_i (phi_q),
         .cap_i (capture),
         .din_i (lane_din[k]),
         .out_o (lane_out[k])
      );
   end

   assign out_0 = lane_out[0];
   assign out_1 = lane_out[1];
   assign out_2 = lane_out[2];
   assign out_3 = lane_out[3];
   assign out_4 = lane_out[4];
   assign out_5 = lane_out[5];
   assign out_6 = lane_out[6];
   assign out_7 = lane_out[7];

   assign out_valid  = outv_q;
   assign clkout_dsp = clkout_q;
   assign underflow  = under_q;

endmodule

// File: tb/tb_ser288to72.sv
// Randomized bench for ser288to72 against a latency-rule reference model.
module tb_ser288to72;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] phi_init = 2'd0;
   logic [8:0] in_w [32];
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [8:0] out_w [8];
   logic       out_valid, clkout_dsp, underflow;
`ifdef SER288TO72_PATTERN_EN
   logic       pattern_en = 1'b0;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: last captured frame and the edge it was taken on.
   int         mphi;
   int         edge_n;
   int         rec_edge;
   bit         have_rec;
   bit         rec_v;
   logic [8:0] rec [32];
   bit         m_under;
   int         pcnt;

   always #5 clk = ~clk;

   ser288to72 dut (
`ifdef SER288TO72_PATTERN_EN
      .pattern_en(pattern_en),
`endif
      .clk(clk), .rst(rst), .phi_init(phi_init),
      .in_0(in_w[0]),   .in_1(in_w[1]),   .in_2(in_w[2]),   .in_3(in_w[3]),
      .in_4(in_w[4]),   .in_5(in_w[5]),   .in_6(in_w[6]),   .in_7(in_w[7]),
      .in_8(in_w[8]),   .in_9(in_w[9]),   .in_10(in_w[10]), .in_11(in_w[11]),
      .in_12(in_w[12]), .in_13(in_w[13]), .in_14(in_w[14]), .in_15(in_w[15]),
      .in_16(in_w[16]), .in_17(in_w[17]), .in_18(in_w[18]), .in_19(in_w[19]),
      .in_20(in_w[20]), .in_21(in_w[21]), .in_22(in_w[22]), .in_23(in_w[23]),
      .in_24(in_w[24]), .in_25(in_w[25]), .in_26(in_w[26]), .in_27(in_w[27]),
      .in_28(in_w[28]), .in_29(in_w[29]), .in_30(in_w[30]), .in_31(in_w[31]),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_0(out_w[0]), .out_1(out_w[1]), .out_2(out_w[2]), .out_3(out_w[3]),
      .out_4(out_w[4]), .out_5(out_w[5]), .out_6(out_w[6]), .out_7(out_w[7]),
      .out_valid(out_valid), .clkout_dsp(clkout_dsp), .underflow(underflow)
   );

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset(input int pi);
      mphi     = pi;
      edge_n   = 0;
      rec_edge = 0;
      have_rec = 0;
      rec_v    = 0;
      m_under  = 0;
      pcnt     = 0;
      for (int i = 0; i < 32; i++) rec[i] = '0;
   endtask

   // Called at a negedge: asserts rst, checks reset values, releases after one posedge.
   task automatic do_reset(input logic [1:0] pi);
      phi_init = pi;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) chk($sformatf("rst_out%0d", k), out_w[k], 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_clkout", clkout_dsp, (pi == 2'd3 || pi == 2'd0) ? 1 : 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset(int'(pi));
      phi_init = 2'($urandom_range(0, 3));
   endtask

   // One fast cycle: inputs are already driven; predict, clock, compare.
   task automatic cycle();
      logic [8:0] e_out [8];
      bit         e_v, e_clk, pat;
      int         d;
      pat = 0;
`ifdef SER288TO72_PATTERN_EN
      pat = pattern_en;
`endif
      chk("in_ready", in_ready, (mphi == 3 && !pat) ? 1 : 0);
      // Word i of a frame captured at edge E shows on lane i%8 after edge E+1+i/8.
      d = edge_n - rec_edge;
      for (int k = 0; k < 8; k++)
         e_out[k] = (have_rec && d >= 1 && d <= 4) ? rec[8*(d-1) + k] : 9'd0;
      e_v   = have_rec && d >= 1 && d <= 4 && rec_v;
      e_clk = (mphi == 3 || mphi == 0);
      if (mphi == 3) begin
         have_rec = 1;
         rec_edge = edge_n;
         if (pat) begin
            for (int i = 0; i < 32; i++) rec[i] = 9'((pcnt + i) % 512);
            pcnt  = (pcnt + 32) % 512;
            rec_v = 1;
         end else if (in_valid) begin
            for (int i = 0; i < 32; i++) rec[i] = in_w[i];
            rec_v = 1;
         end else begin
            for (int i = 0; i < 32; i++) rec[i] = '0;
            rec_v   = 0;
            m_under = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 8; k++) chk($sformatf("out%0d", k), out_w[k], e_out[k]);
      chk("out_valid", out_valid, e_v);
      chk("clkout_dsp", clkout_dsp, e_clk);
      chk("underflow", underflow, m_under);
      mphi = (mphi + 1) % 4;
      edge_n++;
   endtask

   task automatic drive_random(input int valid_pct);
      for (int i = 0; i < 32; i++) in_w[i] = 9'($urandom_range(0, 511));
      in_valid = ($urandom_range(0, 99) < valid_pct);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) in_w[i] = '0;
      @(negedge clk);

      // Idle after reset: zeros, then underflow at the first capture edge.
      do_reset(2'd0);
      in_valid = 1'b0;
      for (int c = 0; c < 6; c++) cycle();

      // Counting frames in_i = 32f+i, valid on every slot.
      do_reset(2'd0);
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < 32; i++) in_w[i] = 9'((32*(c/4) + i) % 512);
         in_valid = 1'b1;
         cycle();
      end

      // One dropped slot mid-stream.
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < 32; i++) in_w[i] = 9'((7*c + 3*i) % 512);
         in_valid = (mphi != 3) || (c < 4 || c > 8);
         cycle();
      end

      // Random traffic; in_valid also toggles on ignored phases.
      for (int c = 0; c < 300; c++) begin
         drive_random(85);
         cycle();
      end

      // Reset during phase 2 with phi_init = 2.
      do_reset(2'd2);
      for (int c = 0; c < 9; c++) begin
         drive_random(100);
         cycle();
      end
      while (mphi != 2) begin
         drive_random(100);
         cycle();
      end
      do_reset(2'd2);
      for (int c = 0; c < 12; c++) begin
         drive_random(100);
         cycle();
      end

      // Resets with random start phases.
      for (int r = 0; r < 6; r++) begin
         do_reset(2'($urandom_range(0, 3)));
         for (int c = 0; c < 30; c++) begin
            drive_random(90);
            cycle();
         end
      end

`ifdef SER288TO72_PATTERN_EN
      // Pattern source over a full 9-bit wrap, with in_valid noise ignored.
      do_reset(2'd0);
      pattern_en = 1'b1;
      for (int c = 0; c < 80; c++) begin
         drive_random(30);
         cycle();
      end
      pattern_en = 1'b0;
      for (int c = 0; c < 12; c++) begin
         drive_random(100);
         cycle();
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ser288to72.md
# ser288to72

Parallel-to-serial counterpart of the 72:288 deserializer. Takes one 32-word × 9-bit frame per divided-by-4 clock period from the DSP/FIFO side and emits it as eight 9-bit lanes per fast clock cycle, over four phases. It sits between the DSP output FIFO and the 72-bit fast-clock transmit datapath. The phase and lane ordering is the exact inverse of the deserializer, so a loopback through both restores `in_k` at `out_k`.

## Interface
- `WIDTH`, 9: bits per word.
- `LANES`, 8: words emitted per fast cycle.
- `clk`  in  1  fast clock. All state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `phi_init`  in  2  phase loaded on reset. Tie to 2'b00 or drive externally.
- `in_0` … `in_31`  in  9 each  frame words.
- `in_valid`  in  1  frame on `in_*` is valid.
- `in_ready`  out  1  frame is accepted at this edge when `in_valid` is also high.
- `out_0` … `out_7`  out  9 each  serialized lane words. Registered.
- `out_valid`  out  1  `out_*` carries accepted data. Registered.
- `clkout_dsp`  out  1  divided-by-4 clock for upstream logic. Registered.
- `underflow`  out  1  sticky flag: a frame slot passed with no valid input.

## Operation
- Phase counter `phi` increments by one each cycle and wraps 3→0.
- `in_ready` is combinational and equals (`phi == 2'b11`). It does not depend on `in_valid`.
- Frame slot at every edge where `phi == 3`:
  - If `in_valid`: `frame <= in_*` and `fvalid <= 1`.
  - Otherwise: `frame <= 0`, `fvalid <= 0`, `underflow <= 1`.
- Lane output at every edge: `out_k <= frame[8*phi + k]` and `out_valid <= fvalid`.
  - Phase 0 edge selects words 0–7; phase 1 selects 8–15; phase 2 selects 16–23; phase 3 selects 24–31.
  - At the phase-3 edge the old frame supplies words 24–31 while the new frame is captured (nonblocking).
- `clkout_dsp <= (phi == 3 || phi == 0)`. Its rising edge coincides with the frame-capture edge, so upstream launches the next frame on it.
- `in_valid` during phases 0–2 is ignored. No frame is accepted and `underflow` is not affected.
- Reset values:
  - `phi = phi_init`.
  - `frame = 0`, `fvalid = 0`, `out_* = 0`, `out_valid = 0`, `underflow = 0`.
  - `clkout_dsp = (phi_init == 3 || phi_init == 0)`.
- Reset mid-frame discards the frame immediately. Output restarts at the first slot after release.

## Timing
- Latency: word `i` of a frame accepted at capture edge E appears on `out_(i mod 8)` after edge E + 1 + floor(i/8).
- Words 0–7 appear one cycle after capture. Words 24–31 appear four cycles after capture, at the next capture edge.
- Throughput: one frame per 4 cycles, sustained with no bubbles.
- `out_valid` toggles only on slot boundaries, i.e. after phase-0 edges.
- `underflow` sets at the edge of an empty slot and holds until `rst`.

## Configuration
- `SER288TO72_PATTERN_EN` defined:
  - Adds input `pattern_en` (1 bit) and an internal 9-bit counter `pcnt`, reset to 0.
  - At a capture edge with `pattern_en = 1`: `frame[i] <= (pcnt + i) mod 512`, `pcnt <= pcnt + 32`, `fvalid <= 1`. `in_*` and `in_valid` are ignored.
  - With `pattern_en = 1`: `in_ready` is forced low and `underflow` is not set.
- Not defined: the port, the counter and the mux are absent, and behaviour is exactly as above.

## Structure
- Shared package `ser_pkg` holds `WIDTH = 9`, `LANES = 8`, `WORDS = 32`, `PHASES = 4`, and typedef `word_t` (`logic [8:0]`).
- One sub-module `ser36to9`: owns the four frame words for one lane and the 4:1 phase mux. The top instantiates it eight times.
- The top owns `phi`, `clkout_dsp`, the handshake and `underflow`.

## Test plan
- Reset with `phi_init = 0`, no input → all `out_*` = 0, `out_valid` = 0, `clkout_dsp` = 1. `underflow` = 1 after the first phase-3 edge.
- Continuous valid frames with `in_i = 32*f + i` (mod 512) → lanes output 0..7, 8..15, 16..23, 24..31, then 32.., with no gaps and `out_valid` steady at 1.
- Loopback into `des72to288` with the same `phi_init` → `out_j` of the deserializer equals the original `in_j` for all 32 words.
- `in_valid` dropped for one slot → exactly 4 cycles of zeros with `out_valid` = 0, `underflow` latched high, and the next frame intact.
- `rst` asserted during phase 2 with `phi_init = 2'b10` → outputs zero at once, and the first capture occurs 2 cycles after release.
- Pattern build, `pattern_en` = 1 → lanes output 0..31, then 32..63, and wrap 511→0; `in_ready` = 0 throughout.
